// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM states, bus address bytes,
// register names and the ROM sequence markers used by the config master.
package sccb_pkg;

  localparam logic [7:0]  DEV_WR     = 8'h42;
  localparam logic [7:0]  DEV_RD     = 8'h43;
  localparam logic [7:0]  REG_COM7   = 8'h12;
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_WAIT_STOP
  } sccb_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_wr_t;

endpackage

// File: rtl/sccb_line_filter.sv
// Pin conditioning for one SCCB line: 2-flop synchronizer followed by a
// glitch filter that only accepts a new level after FILT_LEN equal samples.
// Level resets high (idle bus) so leaving reset never fakes an edge.
module sccb_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // synchronize, count consecutive samples that disagree with the level, flip on FILT_LEN
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          level <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// Camera-side SCCB responder with a 256x8 register file. Writes go through
// an auto-incrementing pointer and are reported as wr_valid events; reads
// stream from the same pointer, which persists across transactions.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h21,
  parameter int         FILT_LEN     = 3,
  parameter logic [7:0] SOFT_RST_REG = REG_COM7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       soft_reset,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_flt (
    .clk(clk), .reset(reset), .din(scl_in),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_flt (
    .clk(clk), .reset(reset), .din(sda_in),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  sccb_state_t state;
  logic [7:0]  shreg, tx, ptr;
  logic [3:0]  bitcnt;
  logic        phase;   // ACK states: 1 once ACK driven; MACK: 1 once master ACKed
  logic        rw;
  logic        sda_oe_q;
  sccb_wr_t    wr_q;
  logic [7:0]  regfile [256];

  logic       start_c, stop_c, commit;
  logic [7:0] rx_nxt;

  assign start_c = sda_fall & scl_f;
  assign stop_c  = sda_rise & scl_f;
  assign rx_nxt  = {shreg[6:0], sda_f};
  assign commit  = ~start_c & ~stop_c & (state == ST_WDATA_ACK) & scl_fall & ~phase;

  // reset must free the bus immediately, not one edge later
  assign sda_oe  = sda_oe_q & ~reset;
  assign busy    = (state != ST_IDLE);
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;

  // register file write on commit; debug port reads old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
      dbg_data <= 8'h00;
    end else begin
      dbg_data <= regfile[dbg_addr];
      if (commit) regfile[ptr] <= shreg;
    end
  end

  // bus protocol FSM: START/STOP override everything, bits in on SCL rise, SDA changes on SCL fall
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= 8'h00;
      tx         <= 8'h00;
      ptr        <= 8'h00;
      bitcnt     <= 4'd0;
      phase      <= 1'b0;
      rw         <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_q       <= '0;
      wr_valid   <= 1'b0;
      soft_reset <= 1'b0;
    end else begin
      wr_valid   <= 1'b0;
      soft_reset <= 1'b0;
      if (start_c) begin
        state    <= ST_DEV;
        bitcnt   <= 4'd0;
        phase    <= 1'b0;
        sda_oe_q <= 1'b0;
      end else if (stop_c) begin
        state    <= ST_IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state)
          ST_DEV, ST_REG, ST_WDATA: begin
            if (scl_rise) begin
              shreg  <= rx_nxt;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                bitcnt <= 4'd0;
                phase  <= 1'b0;
                if (state == ST_DEV) begin
                  if (rx_nxt[7:1] != DEV_ADDR) state <= ST_WAIT_STOP;
                  else begin
                    rw    <= rx_nxt[0];
                    state <= ST_DEV_ACK;
                  end
                end else if (state == ST_REG) begin
                  ptr   <= rx_nxt;
                  state <= ST_REG_ACK;
                end else begin
                  state <= ST_WDATA_ACK;
                end
              end
            end
          end
          ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase    <= 1'b1;
                sda_oe_q <= 1'b1;
                if (commit) begin
                  wr_valid   <= 1'b1;
                  wr_q       <= '{addr: ptr, data: shreg};
                  soft_reset <= (ptr == SOFT_RST_REG) && shreg[7];
                  ptr        <= ptr + 8'd1;
                end
              end else begin
                phase    <= 1'b0;
                bitcnt   <= 4'd0;
                sda_oe_q <= 1'b0;
                if (state == ST_DEV_ACK && rw) begin
                  tx       <= regfile[ptr];
                  sda_oe_q <= ~regfile[ptr][7];
                  state    <= ST_RDATA;
                end else if (state == ST_DEV_ACK) begin
                  state <= ST_REG;
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe_q <= 1'b0;
                phase    <= 1'b0;
                state    <= ST_MACK;
              end else begin
                sda_oe_q <= ~tx[~bitcnt[2:0]];
              end
            end
          end
          ST_MACK: begin
            if (scl_rise) begin
              if (sda_f) state <= ST_WAIT_STOP;
              else begin
                ptr   <= ptr + 8'd1;
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase    <= 1'b0;
              bitcnt   <= 4'd0;
              tx       <= regfile[ptr];
              sda_oe_q <= ~regfile[ptr][7];
              state    <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master with an open-drain bus,
// a register/pointer model, and scoreboards for write events and read data.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 8;  // clocks per quarter of an SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_valid, soft_reset, busy;
  logic [7:0] wr_addr, wr_data, dbg_data;
  logic [7:0] dbg_addr = 8'h00;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  sccb_responder dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .soft_reset(soft_reset), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] d; logic s; } wr_exp_t;

  int         nvec = 0, nerr = 0;
  wr_exp_t    wq[$];
  logic [7:0] rq[$];
  wr_exp_t    e;
  logic [7:0] mdl [256];
  logic [7:0] mptr;
  logic       oe_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // write-event scoreboard and stray drive/soft_reset monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (sda_oe) oe_seen = 1'b1;
      if (wr_valid) begin
        if (wq.size() == 0) chk("wr_unexp", wr_valid, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
          chk("srst", soft_reset, e.s);
        end
      end else if (soft_reset) chk("srst_alone", soft_reset, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, input bit glitch, output logic s);
    m_sda = b;
    tick(Q);
    if (glitch) begin
      m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q);
    end
    m_scl = 1'b1;
    tick(Q);
    s = sda_in;
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input bit exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], 1'b0, s);
    bus_bit(1'b1, 1'b0, s);
    chk("ack", s, exp_ack ? 0 : 1);
  endtask

  task automatic rbyte(input bit mack, input bit glitch, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, glitch && (i == 4), s);
      b[i] = s;
    end
    bus_bit(mack ? 1'b0 : 1'b1, 1'b0, s);
  endtask

  // register write transaction of n (0..2) data bytes, mirrored into the model
  task automatic wr_regs(input logic [7:0] r, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] d;
    i2c_start();
    wbyte(DEV_WR, 1'b1);
    wbyte(r, 1'b1);
    mptr = r;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      wq.push_back('{a: mptr, d: d, s: (mptr == REG_COM7) && d[7]});
      mdl[mptr] = d;
      mptr = mptr + 8'd1;
      wbyte(d, 1'b1);
    end
    i2c_stop();
  endtask

  task automatic rd_regs(input int n, input bit glitch);
    logic [7:0] b;
    i2c_start();
    wbyte(DEV_RD, 1'b1);
    for (int i = 0; i < n; i++) begin
      rq.push_back(mdl[mptr]);
      rbyte(i < n - 1, glitch && (i == 0), b);
      chk("rd_data", b, rq.pop_front());
      if (i < n - 1) mptr = mptr + 8'd1;
    end
    i2c_stop();
  endtask

  task automatic dbg_chk(input logic [7:0] a);
    dbg_addr = a;
    tick(1);
    chk("dbg", dbg_data, mdl[a]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mptr = 8'h00;
    oe_seen = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_wv", wr_valid, 0);
    chk("rst_srst", soft_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbg", dbg_data, 0);

    // single write, then readback over the debug port
    wr_regs(8'h12, 1, 8'h14, 8'h00);
    chk("busy_idle1", busy, 0);
    dbg_chk(8'h12);

    // COM7 bit 7 raises soft_reset alongside wr_valid
    wr_regs(8'h12, 1, 8'h80, 8'h00);
    dbg_chk(8'h12);

    // two-phase read: set data, set pointer, then read with NACK
    wr_regs(8'h3A, 1, 8'h04, 8'h00);
    wr_regs(8'h3A, 0, 8'h00, 8'h00);
    rd_regs(1, 1'b0);
    chk("busy_idle3", busy, 0);

    // foreign device address: no ACK ever, busy until STOP
    oe_seen = 1'b0;
    i2c_start();
    chk("busy_start", busy, 1);
    wbyte(8'h60, 1'b0);
    wbyte(8'h12, 1'b0);
    wbyte(8'h34, 1'b0);
    chk("busy_foreign", busy, 1);
    i2c_stop();
    chk("oe_foreign", oe_seen, 0);
    chk("busy_idle4", busy, 0);

    // pointer wrap on write, then sequential read across the wrap
    wr_regs(8'hFF, 2, 8'hAA, 8'hBB);
    dbg_chk(8'hFF);
    dbg_chk(8'h00);
    wr_regs(8'hFF, 0, 8'h00, 8'h00);
    rd_regs(2, 1'b0);

    // SCL glitch during a read byte must not disturb it
    wr_regs(8'h50, 1, 8'h5A, 8'h00);
    wr_regs(8'h50, 0, 8'h00, 8'h00);
    rd_regs(1, 1'b1);

    // reset while driving bit 7 (a 0) of a read byte
    i2c_start();
    wbyte(DEV_RD, 1'b1);
    chk("oe_rdata", sda_oe, 1);
    reset = 1'b1;
    #1;
    chk("oe_rst_now", sda_oe, 0);
    chk("busy_pre_edge", busy, 1);
    tick(1);
    chk("busy_rst", busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(10);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mptr = 8'h00;
    dbg_chk(8'h50);
    dbg_chk(8'h12);

    tick(4);
    chk("wq_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
Synthesizable SCCB/I2C responder (camera-side end of the configuration bus) with a 256x8 register file. Lets the camera config master and its ROM sequence be checked in simulation and on-board loopback without a sensor. It decodes writes and reads addressed to the camera device address and exposes every committed write as an event. A debug read port gives the video pipeline and the testbench access to register contents.

Parameters:
DEV_ADDR, 7'h21, 7-bit device address; 0x42 on the bus is a write, 0x43 a read.
FILT_LEN, 3, number of consecutive identical synchronized samples needed to accept a new SCL/SDA level.
SOFT_RST_REG, 8'h12, register whose bit 7 written as 1 raises soft_reset.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
scl_in  in  1  raw SCL pin level (asynchronous).
sda_in  in  1  raw SDA pin level (asynchronous).
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
wr_valid  out  1  one-cycle pulse when a write byte is committed.
wr_addr  out  8  register address of the committed write.
wr_data  out  8  data of the committed write.
soft_reset  out  1  one-cycle pulse when SOFT_RST_REG is written with bit 7 = 1.
busy  out  1  high from START until STOP.
dbg_addr  in  8  debug read address.
dbg_data  out  8  regfile[dbg_addr], registered, valid 1 cycle after dbg_addr.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; regfile cleared to 0x00; pointer 0x00; state IDLE. A reset mid-transfer releases SDA in the same cycle and drops the transaction.
- Input conditioning: 2-flop synchronizer, then glitch filter. A new level is accepted after FILT_LEN equal samples. Edge latency from pin to internal edge is 2+FILT_LEN cycles. Single-cycle glitches never produce edges.
- START: filtered SDA falls while SCL is high. Accepted in any state; a repeated start goes to DEV state and clears the bit counter.
- STOP: filtered SDA rises while SCL is high. Accepted in any state; goes to IDLE and sets sda_oe = 0.
- Bit sampling: SDA is sampled on the SCL rising edge. All SDA output changes happen on the SCL falling edge. Shifting is MSB first.
- States:
  - IDLE
  - DEV (8 bits)
  - DEV_ACK
  - REG (8 bits)
  - REG_ACK
  - WDATA (8 bits)
  - WDATA_ACK
  - RDATA (8 bits driven)
  - MACK (sample the master's ACK/NACK)
  - WAIT_STOP
- DEV byte:
  - Upper 7 bits != DEV_ADDR: go to WAIT_STOP, never acknowledge.
  - R/W = 0: go to DEV_ACK, then REG.
  - R/W = 1: go to DEV_ACK, then RDATA, using the current pointer.
- ACK: on the SCL falling edge after the 8th bit, sda_oe = 1. Released on the next SCL falling edge. In read mode, that same falling edge instead drives the first data bit.
- REG byte: loads the pointer and is acknowledged. Following bytes go to WDATA.
- WDATA byte: committed on the cycle the ACK is asserted:
  - regfile[pointer] is written.
  - wr_valid pulses, with wr_addr = pointer and wr_data = byte.
  - The pointer then increments, wrapping 0xFF -> 0x00.
- soft_reset pulses in the same cycle as wr_valid when pointer == SOFT_RST_REG and data[7] = 1. The regfile itself is not cleared.
- RDATA: sda_oe = ~bit, so only a 0 is driven; a 1 means release. After 8 bits, SDA is released for MACK.
  - Master ACK (SDA low): pointer increments (wrapping), next byte is loaded.
  - Master NACK: go to WAIT_STOP.
- The two-phase SCCB read (write REG, STOP, START, read) works because the pointer persists across transactions.
- Debug port: if dbg_addr equals the address being written in the same cycle, dbg_data returns the old value (read-before-write).
- busy = (state != IDLE).

Decomposition:
- Package sccb_pkg holds:
  - the state enum;
  - DEV_WR = 8'h42 and DEV_RD = 8'h43;
  - REG_COM7 = 8'h12;
  - the ROM markers END_MARK = 16'hFFFF and DELAY_MARK = 16'hFFF0, shared with the config master.
- Sub-module sccb_line_filter (synchronizer + glitch filter + rise/fall edge pulses), instantiated once for SCL and once for SDA.

Test Plan:
- Write 0x42,0x12,0x14 then STOP -> 3 ACKs; a single wr_valid with addr 0x12, data 0x14; soft_reset stays 0; dbg_addr = 0x12 returns 0x14.
- Write 0x42,0x12,0x80 -> wr_valid plus a soft_reset pulse in the same cycle.
- Write 0x42,0x3A,0x04, STOP; then 0x42,0x3A, STOP; START, 0x43, master NACK -> responder drives 0x04; goes to IDLE after STOP.
- Address 0x60 followed by 2 bytes -> sda_oe never asserts; no wr_valid; busy until STOP.
- Write 0x42,0xFF,0xAA,0xBB -> regfile[0xFF] = 0xAA, regfile[0x00] = 0xBB (wrap); two wr_valid pulses.
- 1-cycle SCL glitch mid-byte, then reset asserted during RDATA -> glitch ignored (byte still correct); on reset, sda_oe = 0 in the same cycle and busy = 0 next cycle.
